// File: rtl/riscv_pkg.sv
// Shared RV32I encoder definitions: format codes, fixed opcodes, encoder states.
package riscv_pkg;

  // Codes 000-011 line up with the immediate extender's immsrc encoding.
  typedef enum logic [2:0] {
    FMT_I     = 3'b000,
    FMT_S     = 3'b001,
    FMT_B     = 3'b010,
    FMT_J     = 3'b011,
    FMT_U     = 3'b100,
    FMT_LI    = 3'b101,
    FMT_R     = 3'b110,
    FMT_UNDEF = 3'b111
  } fmt_e;

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LI2  = 1'b1
  } state_e;

  // True when every bit of v from position lsb upward equals bit 31.
  function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lsb);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i >= lsb && v[i] != v[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational field packer: builds the instruction word(s) and flags
// unrepresentable immediates. LI may yield a second (ADDI) word.
module imm_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        err_o,
  output logic [31:0] word2_o,
  output logic        two_beat_o
);

  fmt_e        fmt;
  logic [19:0] li_hi;
  logic        fits12;

  assign fmt    = fmt_e'(fmt_i);
  assign fits12 = upper_uniform(imm_i, 11);
  // (imm + 0x800) >> 12 with 32-bit wrap: the carry into bit 12 is imm[11].
  assign li_hi  = imm_i[31:12] + {19'd0, imm_i[11]};

  // Format-dependent packing and range check.
  always_comb begin
    word_o     = '0;
    err_o      = 1'b0;
    word2_o    = '0;
    two_beat_o = 1'b0;
    unique case (fmt)
      FMT_I: begin
        word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        err_o  = !fits12;
      end
      FMT_S: begin
        word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        err_o  = !fits12;
      end
      FMT_B: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                  imm_i[4:1], imm_i[11], opcode_i};
        err_o  = !upper_uniform(imm_i, 12) || imm_i[0];
      end
      FMT_J: begin
        word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        err_o  = !upper_uniform(imm_i, 20) || imm_i[0];
      end
      FMT_U: begin
        word_o = {imm_i[31:12], rd_i, opcode_i};
        err_o  = (imm_i[11:0] != 12'd0);
      end
      FMT_LI: begin
        if (fits12) begin
          word_o = {imm_i[11:0], 5'd0, 3'b000, rd_i, OP_IMM};
        end else begin
          word_o     = {li_hi, rd_i, OP_LUI};
          word2_o    = {imm_i[11:0], rd_i, 3'b000, rd_i, OP_IMM};
          two_beat_o = 1'b1;
        end
      end
      FMT_R: begin
        word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      default: begin
        err_o = 1'b1;
      end
    endcase
    if (err_o) word_o = '0;
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with valid/ready on both sides and a registered
// output; expands two-beat LI into LUI followed by ADDI.
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic [31:0] pend_q, pend_d;

  logic [31:0] pk_word, pk_word2;
  logic        pk_err, pk_two;
  logic        in_fire, out_fire;

  imm_pack u_imm_pack (
    .fmt_i      (in_fmt),
    .opcode_i   (in_opcode),
    .funct3_i   (in_funct3),
    .funct7_i   (in_funct7),
    .rd_i       (in_rd),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .imm_i      (in_imm),
    .word_o     (pk_word),
    .err_o      (pk_err),
    .word2_o    (pk_word2),
    .two_beat_o (pk_two)
  );

  assign in_ready  = (state_q == S_IDLE) && (!valid_q || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign out_last  = last_q;

  // Next-state and output-register load logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    instr_d = instr_q;
    err_d   = err_q;
    last_d  = last_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          valid_d = 1'b1;
          instr_d = pk_word;
          err_d   = pk_err;
          last_d  = !pk_two;
          if (pk_two) begin
            pend_d  = pk_word2;
            state_d = S_LI2;
          end
        end else if (out_fire) begin
          valid_d = 1'b0;
        end
      end
      S_LI2: begin
        if (out_fire) begin
          instr_d = pend_q;
          err_d   = 1'b0;
          last_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      instr_q <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and round-trip bench for instr_encoder.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_last;

  int n_cmp = 0;
  int n_bad = 0;

  instr_encoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int unsigned n;
    in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check_eq("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Reference immediate extender, driven by immsrc codes 0..3.
  function automatic logic [31:0] extend(input logic [1:0] src, input logic [31:0] w);
    case (src)
      2'd0:    return {{20{w[31]}}, w[31:20]};
      2'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      2'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  task automatic check_beat(input string tag, input logic [31:0] instr, input logic err,
                            input logic last);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_instr"}, out_instr, instr);
    check_eq({tag, "_err"}, {31'd0, out_err}, {31'd0, err});
    check_eq({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
  endtask

  initial begin
    logic [31:0] v, imm;
    logic [1:0]  src;

    #12;
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_instr", out_instr, 32'd0);
    check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // I-type addi x5, x6, -1
    send(3'b000, 7'h13, 3'd0, 7'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk) check_beat("i_type", 32'hFFF3_0293, 1'b0, 1'b1);

    // Two-beat LI
    send(3'b101, 7'd0, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
    @(negedge clk) check_beat("li2_b1", 32'h1234_6537, 1'b0, 1'b0);
    check_eq("li2_ready_mid", {31'd0, in_ready}, 32'd0);
    @(negedge clk) check_beat("li2_b2", 32'hFFF5_0513, 1'b0, 1'b1);
    @(negedge clk) check_eq("li2_drained", {31'd0, out_valid}, 32'd0);
    check_eq("li2_ready_after", {31'd0, in_ready}, 32'd1);

    // Single-beat LI
    @(posedge clk); #1;
    send(3'b101, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd100);
    @(negedge clk) check_beat("li1", 32'h0640_0093, 1'b0, 1'b1);

    // B range
    send(3'b010, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4096);
    @(negedge clk) check_beat("b_4096", 32'd0, 1'b1, 1'b1);
    send(3'b010, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    @(negedge clk) check_beat("b_odd", 32'd0, 1'b1, 1'b1);
    send(3'b010, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_F000);
    @(negedge clk) check_beat("b_m4096", 32'h8020_8063, 1'b0, 1'b1);

    // Other formats and errors
    send(3'b100, 7'h37, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'h1234_5000);
    @(negedge clk) check_beat("u_ok", 32'h1234_51B7, 1'b0, 1'b1);
    send(3'b100, 7'h37, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'h1234_5001);
    @(negedge clk) check_beat("u_err", 32'd0, 1'b1, 1'b1);
    send(3'b110, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF);
    @(negedge clk) check_beat("r_sub", 32'h4031_00B3, 1'b0, 1'b1);
    send(3'b011, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    @(negedge clk) check_beat("j_2048", 32'h0010_00EF, 1'b0, 1'b1);
    send(3'b111, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    @(negedge clk) check_beat("fmt_undef", 32'd0, 1'b1, 1'b1);
    @(negedge clk);

    // Backpressure on LI beat 1
    out_ready = 1'b0;
    @(posedge clk); #1;
    send(3'b101, 7'd0, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_beat("bp_hold", 32'h1234_6537, 1'b0, 1'b0);
      check_eq("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk) check_beat("bp_b2", 32'hFFF5_0513, 1'b0, 1'b1);
    @(negedge clk) check_eq("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset while in S_LI2
    out_ready = 1'b0;
    @(posedge clk); #1;
    send(3'b101, 7'd0, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
    @(negedge clk) reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_instr", out_instr, 32'd0);
    check_eq("mid_rst_err", {31'd0, out_err}, 32'd0);
    check_eq("mid_rst_last", {31'd0, out_last}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(3'b000, 7'h13, 3'd0, 7'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk) check_beat("post_rst", 32'hFFF3_0293, 1'b0, 1'b1);

    // Random in-range I/S/B/J round trip through the reference extender
    for (int i = 0; i < 10000; i++) begin
      src = 2'($urandom_range(0, 3));
      case (src)
        2'd0, 2'd1: begin v = $urandom_range(0, 4095);     imm = {{20{v[11]}}, v[11:0]}; end
        2'd2:       begin v = $urandom_range(0, 8191) & 32'hFFFF_FFFE;
                          imm = {{19{v[12]}}, v[12:0]}; end
        default:    begin v = $urandom_range(0, 2097151) & 32'hFFFF_FFFE;
                          imm = {{11{v[20]}}, v[20:0]}; end
      endcase
      send({1'b0, src}, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
           5'($urandom), 5'($urandom), imm);
      @(negedge clk);
      check_eq("rt_err", {31'd0, out_err}, 32'd0);
      check_eq("rt_imm", extend(src, out_instr), imm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
